// File: rtl/axi_rresp_ctrl.sv
// -----------------------------------------------------------------------------
// axi_rresp_ctrl
//
// Read-response controller for an AXI slave. Accepted AR commands are queued
// ({id, len, offset}). For each command at the queue head the controller loads
// the upstream converting FIFO's lane pointer (fifo_saddr_init). It then pops
// len+1 beats from that FIFO and presents them on the R channel with the
// matching RID and RLAST. The R channel is fully registered. A new beat is
// popped in the same cycle as the current one is accepted, so bursts stream at
// full rate.
//
// Optional feature (macro AXI_RRESP_CHK_EN):
//   When defined, each popped beat's fifo_rlast is compared with the
//   controller's own end-of-burst position. A mismatching beat is returned
//   with SLVERR (2'b10), and the sticky err_len flag is set. Only rst clears
//   err_len. When undefined, s_rresp is always OKAY and err_len is tied low.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_*               AR command push interface (valid/ready, id, len, offset)
//   fifo_*              upstream read-data FIFO: status/head in, pop and
//                       head-command info / lane-pointer load strobe out
//   s_r*                AXI R channel towards the master
//   err_len             sticky burst-length mismatch flag
//   busy                any command outstanding or R beat held
// -----------------------------------------------------------------------------
module axi_rresp_ctrl #(
   parameter int ID_WTH    = 4,
   parameter int R_WTH     = 32,
   parameter int OFFS_WTH  = 1,
   parameter int CMD_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ID_WTH-1:0]   cmd_id,
   input  logic [7:0]          cmd_len,
   input  logic [OFFS_WTH-1:0] cmd_offset,
   input  logic                fifo_empty,
   input  logic [R_WTH-1:0]    fifo_rdata,
   input  logic                fifo_rlast,
   output logic                fifo_ren,
   output logic [7:0]          fifo_arlen,
   output logic [OFFS_WTH-1:0] fifo_offset,
   output logic                fifo_saddr_init,
   output logic                s_rvalid,
   input  logic                s_rready,
   output logic [R_WTH-1:0]    s_rdata,
   output logic [ID_WTH-1:0]   s_rid,
   output logic [1:0]          s_rresp,
   output logic                s_rlast,
   output logic                err_len,
   output logic                busy
);

   localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ID_WTH + 8 + OFFS_WTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INIT   = 2'd1,
      STREAM = 2'd2
   } state_t;

   // Command queue
   logic [ENT_W-1:0]    cmdq_q [CMD_DEPTH];
   logic [ENT_W-1:0]    cmdq_d [CMD_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   // Control and R channel
   state_t              state_q, state_d;
   logic                saddr_init_q, saddr_init_d;
   logic [8:0]          beat_cnt_q, beat_cnt_d;
   logic                rvalid_q, rvalid_d;
   logic [R_WTH-1:0]    rdata_q, rdata_d;
   logic [ID_WTH-1:0]   rid_q, rid_d;
   logic                rlast_q, rlast_d;

   logic [ENT_W-1:0]    head_s;
   logic [ID_WTH-1:0]   head_id_s;
   logic [7:0]          head_len_s;
   logic [OFFS_WTH-1:0] head_offs_s;
   logic                q_empty_s;
   logic                q_full_s;
   logic                push_s;
   logic                beats_left_s;
   logic                last_beat_s;
   logic                ren_s;
   logic                cmd_pop_s;

   assign head_s      = cmdq_q[rd_ptr_q];
   assign head_id_s   = head_s[ENT_W-1 -: ID_WTH];
   assign head_len_s  = head_s[OFFS_WTH +: 8];
   assign head_offs_s = head_s[OFFS_WTH-1:0];

   assign q_empty_s = (count_q == {CNT_W{1'b0}});
   assign q_full_s  = (count_q == CNT_W'(CMD_DEPTH));
   // A full queue never pushes, even if the head retires in the same cycle.
   assign push_s    = cmd_valid && !q_full_s;

   // 9-bit counter against zero-extended len: len=255 gives 256 beats without wrap.
   assign beats_left_s = (beat_cnt_q <= {1'b0, head_len_s});
   assign last_beat_s  = (beat_cnt_q == {1'b0, head_len_s});

   // Pop only when the output register is free or being emptied this cycle.
   assign ren_s     = (state_q == STREAM) && !fifo_empty && (!rvalid_q || s_rready) && beats_left_s;
   assign cmd_pop_s = ren_s && last_beat_s;

   // Command queue bookkeeping: storage write, pointers and occupancy.
   always_comb begin
      cmdq_d   = cmdq_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         cmdq_d[wr_ptr_q] = {cmd_id, cmd_len, cmd_offset};
         wr_ptr_d         = wr_ptr_q + PTR_W'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (cmd_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, cmd_pop_s})
         2'b10:   count_d = count_q + CNT_W'(1'b1);
         2'b01:   count_d = count_q - CNT_W'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Sequencer: IDLE -> INIT (lane-pointer load) -> STREAM until the last beat pops.
   always_comb begin
      state_d      = state_q;
      saddr_init_d = 1'b0;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (!q_empty_s) begin
               state_d      = INIT;
               saddr_init_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         INIT: begin
            state_d    = STREAM;
            beat_cnt_d = 9'd0;
         end
         STREAM: begin
            if (cmd_pop_s) begin
               state_d = IDLE;
            end else begin
               state_d = STREAM;
            end
            if (ren_s) begin
               beat_cnt_d = beat_cnt_q + 9'd1;
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
         end
         default: begin
            state_d    = IDLE;
            beat_cnt_d = 9'd0;
         end
      endcase
   end

   // R channel register: load on pop, drop valid on accept, otherwise hold.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rid_d    = rid_q;
      rlast_d  = rlast_q;
      if (ren_s) begin
         rvalid_d = 1'b1;
         rdata_d  = fifo_rdata;
         rid_d    = head_id_s;
         rlast_d  = last_beat_s;
      end else if (s_rready) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
   end

   // State registers for queue, sequencer and R channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CMD_DEPTH; i++) begin
            cmdq_q[i] <= {ENT_W{1'b0}};
         end
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         state_q      <= IDLE;
         saddr_init_q <= 1'b0;
         beat_cnt_q   <= 9'd0;
         rvalid_q     <= 1'b0;
         rdata_q      <= {R_WTH{1'b0}};
         rid_q        <= {ID_WTH{1'b0}};
         rlast_q      <= 1'b0;
      end else begin
         cmdq_q       <= cmdq_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         saddr_init_q <= saddr_init_d;
         beat_cnt_q   <= beat_cnt_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
         rid_q        <= rid_d;
         rlast_q      <= rlast_d;
      end
   end

`ifdef AXI_RRESP_CHK_EN
   logic [1:0] rresp_q, rresp_d;
   logic       err_q, err_d;
   logic       chk_bad_s;

   // The FIFO's own last flag must line up with the controller's beat count.
   assign chk_bad_s = (fifo_rlast != last_beat_s);

   // Response code follows the beat; mismatch flag is sticky until reset.
   always_comb begin
      rresp_d = rresp_q;
      err_d   = err_q;
      if (ren_s) begin
         rresp_d = chk_bad_s ? 2'b10 : 2'b00;
         err_d   = err_q || chk_bad_s;
      end else begin
         rresp_d = rresp_q;
         err_d   = err_q;
      end
   end

   // Response and error flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rresp_q <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         rresp_q <= rresp_d;
         err_q   <= err_d;
      end
   end

   assign s_rresp = rresp_q;
   assign err_len = err_q;
`else
   logic unused_rlast_s;
   assign unused_rlast_s = fifo_rlast;
   assign s_rresp        = 2'b00;
   assign err_len        = 1'b0;
`endif

   assign cmd_ready       = !q_full_s;
   assign fifo_ren        = ren_s;
   assign fifo_arlen      = head_len_s;
   assign fifo_offset     = head_offs_s;
   assign fifo_saddr_init = saddr_init_q;
   assign s_rvalid        = rvalid_q;
   assign s_rdata         = rdata_q;
   assign s_rid           = rid_q;
   assign s_rlast         = rlast_q;
   assign busy            = (state_q != IDLE) || rvalid_q || !q_empty_s;

endmodule

// File: tb/tb_axi_rresp_ctrl.sv
// Bench for axi_rresp_ctrl. The model is a set of queues: planned commands,
// upstream FIFO contents and the expected R beats in order. A negedge process
// compares every R handshake, payload stability under stall and head-command
// info at every lane-pointer load. Directed tests add literal expectations.
module tb_axi_rresp_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_id;
   logic [7:0]  cmd_len;
   logic [0:0]  cmd_offset;
   logic        fifo_empty;
   logic [31:0] fifo_rdata;
   logic        fifo_rlast;
   logic        fifo_ren;
   logic [7:0]  fifo_arlen;
   logic [0:0]  fifo_offset;
   logic        fifo_saddr_init;
   logic        s_rvalid;
   logic        s_rready;
   logic [31:0] s_rdata;
   logic [3:0]  s_rid;
   logic [1:0]  s_rresp;
   logic        s_rlast;
   logic        err_len;
   logic        busy;

   always #5 clk = ~clk;

   axi_rresp_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
      .cmd_len(cmd_len), .cmd_offset(cmd_offset),
      .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rlast(fifo_rlast),
      .fifo_ren(fifo_ren), .fifo_arlen(fifo_arlen), .fifo_offset(fifo_offset),
      .fifo_saddr_init(fifo_saddr_init),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
      .s_rresp(s_rresp), .s_rlast(s_rlast), .err_len(err_len), .busy(busy)
   );

   typedef struct {logic [31:0] d; logic [3:0] id; logic last; logic [1:0] resp;} beat_t;
   typedef struct {logic [31:0] d; logic last;} fbeat_t;
   typedef struct {logic [3:0] id; logic [7:0] len; logic [0:0] off;} cmd_t;

   beat_t  exp_q[$];
   fbeat_t fifo_q[$];
   cmd_t   cmd_pend[$];
   cmd_t   init_q[$];

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   bit ren_seen = 1'b0;
   bit acc_seen = 1'b0;
   bit fifo_hold = 1'b0;
   int rdy_mode = 0;
   int rx_n, rlast_n, first_hs, last_hs, acc_n, acc5_cyc, first_last_cyc, sinit_n, stall_n;
   logic [31:0] rx_first;
   logic [1:0]  rx_first_resp;
   bit prev_stall = 1'b0;
   bit prev_saddr = 1'b0;
   logic [38:0] prev_pay;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic clr();
      rx_n = 0; rlast_n = 0; first_hs = 0; last_hs = 0; acc_n = 0;
      acc5_cyc = 0; first_last_cyc = 0; sinit_n = 0; stall_n = 0;
      rx_first = 32'h0; rx_first_resp = 2'b00;
   endtask

   // Plan one burst: the command, its FIFO data and the beats it must produce.
   task automatic plan_burst(input logic [3:0] id, input logic [7:0] len, input logic [0:0] off,
                             input logic [31:0] base, input int rlast_at);
      cmd_t c; fbeat_t f; beat_t b;
      c.id = id; c.len = len; c.off = off;
      cmd_pend.push_back(c);
      for (int i = 0; i <= int'(len); i++) begin
         f.d = base + 32'(i);
         f.last = (i == rlast_at);
         fifo_q.push_back(f);
         b.d = f.d; b.id = id; b.last = (i == int'(len));
`ifdef AXI_RRESP_CHK_EN
         b.resp = (f.last != b.last) ? 2'b10 : 2'b00;
`else
         b.resp = 2'b00;
`endif
         exp_q.push_back(b);
      end
   endtask

   task automatic drive();
      cmd_valid = (cmd_pend.size() > 0);
      if (cmd_pend.size() > 0) begin
         cmd_id = cmd_pend[0].id; cmd_len = cmd_pend[0].len; cmd_offset = cmd_pend[0].off;
      end else begin
         cmd_id = 4'h0; cmd_len = 8'h00; cmd_offset = 1'b0;
      end
      fifo_empty = fifo_hold || (fifo_q.size() == 0);
      if (fifo_q.size() > 0) begin
         fifo_rdata = fifo_q[0].d; fifo_rlast = fifo_q[0].last;
      end else begin
         fifo_rdata = 32'h0; fifo_rlast = 1'b0;
      end
      s_rready = (rdy_mode == 0) ? 1'b1 : ((ncyc % 3) == 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ren_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (acc_seen && cmd_pend.size() > 0) init_q.push_back(cmd_pend.pop_front());
      drive();
   endtask

   task automatic wait_done(input int budget, input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || cmd_pend.size() != 0 || busy) && n < budget) begin
         tick();
         n++;
      end
      chk(nm, 64'(n < budget), 64'd1);
   endtask

   // Compare process: inputs are stable here, so values equal those at the next posedge.
   always @(negedge clk) begin
      cmd_t c;
      beat_t b;
      ncyc++;
      ren_seen = fifo_ren;
      acc_seen = cmd_valid && cmd_ready;
      if (rst) begin
         prev_stall = 1'b0;
         prev_saddr = 1'b0;
      end else begin
         if (fifo_ren) chk("ren_when_empty", fifo_empty, 1'b0);
         if (s_rvalid && !s_rready) begin
            chk("ren_while_stalled", fifo_ren, 1'b0);
            stall_n++;
         end
         if (prev_stall) chk("r_hold", {s_rvalid, s_rdata, s_rid, s_rlast, s_rresp}, {1'b1, prev_pay});
         if (fifo_saddr_init) begin
            sinit_n++;
            chk("saddr_pulse_len", prev_saddr, 1'b0);
            if (init_q.size() == 0) chk("saddr_unexpected", 1'b1, 1'b0);
            else begin
               c = init_q.pop_front();
               chk("head_cmd", {fifo_arlen, fifo_offset}, {c.len, c.off});
            end
         end
         if (s_rvalid && s_rready) begin
            if (exp_q.size() == 0) chk("r_unexpected", {s_rvalid, s_rdata}, 33'h0);
            else begin
               b = exp_q.pop_front();
               chk("r_beat", {s_rdata, s_rid, s_rlast, s_rresp}, {b.d, b.id, b.last, b.resp});
               if (rx_n == 0) begin
                  first_hs = ncyc; rx_first = s_rdata; rx_first_resp = s_rresp;
               end
               rx_n++;
               last_hs = ncyc;
               if (s_rlast) begin
                  rlast_n++;
                  if (rlast_n == 1) first_last_cyc = ncyc;
               end
            end
         end
         if (acc_seen) begin
            acc_n++;
            if (acc_n == 5) acc5_cyc = ncyc;
         end
         prev_stall = s_rvalid && !s_rready;
         prev_pay   = {s_rdata, s_rid, s_rlast, s_rresp};
         prev_saddr = fifo_saddr_init;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      clr();
      drive();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rvalid", s_rvalid, 1'b0);
      chk("rst_rpayload", {s_rdata, s_rid, s_rresp, s_rlast}, 39'h0);
      chk("rst_ren_init", {fifo_ren, fifo_saddr_init}, 2'b00);
      chk("rst_err_len", err_len, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);

      // Single burst id=3 len=3 offset=1, ready always high.
      clr();
      plan_burst(4'h3, 8'd3, 1'b1, 32'hD000_0000, 3);
      wait_done(60, "t1_timeout");
      chk("t1_beats", rx_n, 4);
      chk("t1_back_to_back", last_hs - first_hs, 3);
      chk("t1_rlast_count", rlast_n, 1);
      chk("t1_saddr_pulses", sinit_n, 1);
      chk("t1_first_data", rx_first, 32'hD000_0000);

      // Same burst with ready pattern 1,0,0,1,...
      clr();
      rdy_mode = 1;
      plan_burst(4'h3, 8'd3, 1'b1, 32'hE000_0000, 3);
      wait_done(100, "t2_timeout");
      chk("t2_beats", rx_n, 4);
      chk("t2_stalls_seen", 64'(stall_n > 0), 64'd1);
      rdy_mode = 0;

      // Five commands while the data FIFO is held empty.
      clr();
      fifo_hold = 1'b1;
      for (int k = 0; k < 5; k++) plan_burst(4'(k + 1), 8'd1, 1'(k), 32'h3000_0000 + 32'(k * 16), 1);
      repeat (12) tick();
      chk("t3_cmd_ready_full", cmd_ready, 1'b0);
      chk("t3_accepted", 64'(cmd_pend.size()), 64'd1);
      chk("t3_busy", busy, 1'b1);
      fifo_hold = 1'b0;
      wait_done(200, "t3_timeout");
      chk("t3_fifth_after_first", 64'(acc5_cyc >= first_last_cyc && first_last_cyc > 0), 64'd1);
      chk("t3_beats", rx_n, 10);
      chk("t3_rlast_count", rlast_n, 5);

      // len=255: 256 beats at full rate.
      clr();
      plan_burst(4'h9, 8'd255, 1'b1, 32'h4000_0000, 255);
      wait_done(400, "t4_timeout");
      chk("t4_beats", rx_n, 256);
      chk("t4_rlast_count", rlast_n, 1);
      chk("t4_throughput", last_hs - first_hs, 255);

      // len=1 with the FIFO's last flag on the first beat.
      clr();
      plan_burst(4'h6, 8'd1, 1'b0, 32'h5000_0000, 0);
      wait_done(60, "t5_timeout");
`ifdef AXI_RRESP_CHK_EN
      chk("t5_first_resp", rx_first_resp, 2'b10);
      chk("t5_err_len", err_len, 1'b1);
`else
      chk("t5_first_resp", rx_first_resp, 2'b00);
      chk("t5_err_len", err_len, 1'b0);
`endif
      clr();
      plan_burst(4'h2, 8'd0, 1'b0, 32'h5100_0000, 0);
      wait_done(60, "t5b_timeout");
`ifdef AXI_RRESP_CHK_EN
      chk("t5_err_len_held", err_len, 1'b1);
`else
      chk("t5_err_len_held", err_len, 1'b0);
`endif

      // Reset on beat 2 of a len=7 burst with a second command queued.
      clr();
      plan_burst(4'h7, 8'd7, 1'b1, 32'h6000_0000, 7);
      plan_burst(4'h8, 8'd2, 1'b0, 32'h6100_0000, 2);
      n = 0;
      while (rx_n < 2 && n < 40) begin
         tick();
         n++;
      end
      chk("t6_reach_beat2", 64'(n < 40), 64'd1);
      rst = 1'b1;
      exp_q.delete(); fifo_q.delete(); cmd_pend.delete(); init_q.delete();
      drive();
      @(negedge clk);
      chk("t6_rvalid_in_rst", s_rvalid, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_post_rvalid", s_rvalid, 1'b0);
         chk("t6_post_busy", busy, 1'b0);
         chk("t6_post_cmd_ready", cmd_ready, 1'b1);
      end
      chk("t6_err_len", err_len, 1'b0);
      tick();
      clr();
      plan_burst(4'hA, 8'd2, 1'b1, 32'h7000_0000, 2);
      wait_done(60, "t6_timeout");
      chk("t6_after_beats", rx_n, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_rresp_ctrl.md
AXI_RRESP_CTRL -- requirements
Module: axi_rresp_ctrl

Interface
REQ-001 SHALL have parameter ID_WTH, default 4: AXI ID width.
REQ-002 SHALL have parameter R_WTH, default 32: slave-side read data width.
REQ-003 SHALL have parameter OFFS_WTH, default 1: narrow-lane start offset width (log2(W_WTH/R_WTH) of the upstream converting FIFO).
REQ-004 SHALL have parameter CMD_DEPTH, default 4: command queue entries, power of two.
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  accepted AR command present
- cmd_ready  out  1  command queue not full
- cmd_id  in  ID_WTH  ARID
- cmd_len  in  8  ARLEN (beats-1)
- cmd_offset  in  OFFS_WTH  start lane within wide word
- fifo_empty  in  1  upstream rdata FIFO empty
- fifo_rdata  in  R_WTH  FIFO head data, valid while !fifo_empty
- fifo_rlast  in  1  FIFO head last flag
- fifo_ren  out  1  pop FIFO head
- fifo_arlen  out  8  head command length to FIFO
- fifo_offset  out  OFFS_WTH  head command offset to FIFO
- fifo_saddr_init  out  1  one-cycle lane-pointer load strobe
- s_rvalid  out  1  R channel valid
- s_rready  in  1  R channel ready
- s_rdata  out  R_WTH  R data
- s_rid  out  ID_WTH  R ID
- s_rresp  out  2  R response
- s_rlast  out  1  R last
- err_len  out  1  sticky burst-length mismatch flag
- busy  out  1  command outstanding or R beat held

Function
REQ-006 Command queue: FIFO of {id,len,offset}, CMD_DEPTH entries; push on cmd_valid&&cmd_ready; cmd_ready = !full; simultaneous push and pop on a full queue SHALL NOT push (cmd_ready low).
REQ-007 FSM states IDLE, INIT, STREAM.
REQ-008 IDLE -> INIT when queue non-empty; in INIT fifo_saddr_init=1 for exactly one cycle, beat counter cleared; INIT -> STREAM unconditionally.
REQ-009 fifo_arlen/fifo_offset SHALL reflect queue head combinationally in all states.
REQ-010 STREAM: fifo_ren = !fifo_empty && (!s_rvalid || s_rready) && beats_remaining; never asserted outside STREAM.
REQ-011 On fifo_ren, next cycle: s_rvalid=1, s_rdata=fifo_rdata, s_rid=head id, s_rlast=(counter==len), counter+1; latency FIFO head to s_rvalid = 1 cycle.
REQ-012 s_rvalid and all R payload SHALL hold stable while s_rvalid&&!s_rready.
REQ-013 s_rvalid clears on s_rready when no new pop in the same cycle; pop and handshake in the same cycle give back-to-back beats (full throughput within a burst).
REQ-014 When the beat with counter==len is popped, queue head SHALL pop and FSM -> IDLE; one bubble cycle per burst boundary permitted.
REQ-015 Counter is 9 bits; len=255 SHALL yield exactly 256 beats without wrap.
REQ-016 busy = (state!=IDLE) || s_rvalid || queue non-empty.

Reset
REQ-017 On rst: queue empty, FSM IDLE, counter 0, s_rvalid=0, s_rdata=0, s_rid=0, s_rresp=0, s_rlast=0, fifo_ren=0, fifo_saddr_init=0, err_len=0, cmd_ready=1 after release.
REQ-018 rst mid-burst SHALL discard all commands and the held beat; no partial beat presented after release.

Configuration
REQ-019 Macro AXI_RRESP_CHK_EN defined: on each pop compare fifo_rlast with (counter==len); on mismatch that beat carries s_rresp=2'b10 (SLVERR) and err_len sets, cleared only by rst.
REQ-020 Macro undefined: no comparison logic, s_rresp constant 2'b00, err_len tied 0.

Verification
REQ-021 Single command id=3,len=3,offset=1; FIFO holds 4 beats D0..D3 with rlast on D3, s_rready=1 -> fifo_saddr_init one pulse, 4 consecutive s_rvalid beats D0..D3, s_rid=3, s_rlast only on D3.
REQ-022 Same burst with s_rready toggling 1,0,0,1,... -> payload stable during stalls, no beat lost or duplicated, fifo_ren low while stalled.
REQ-023 Push 5 commands while FIFO empty -> cmd_ready drops after 4th; 5th accepted only after first burst completes.
REQ-024 len=255, FIFO always non-empty -> exactly 256 beats, s_rlast on beat 256 only.
REQ-025 With AXI_RRESP_CHK_EN, len=1 but fifo_rlast on first beat -> beat 0 s_rresp=2'b10, err_len=1 and held; without the macro s_rresp=2'b00, err_len=0.
REQ-026 Assert rst on beat 2 of len=7 -> s_rvalid=0 next cycle, queue empty, busy=0 after release.
